// File: rtl/pwm_pkg.sv
// Shared types for the PWM LED bank: per-channel mode and breathe ramp direction.
package pwm_pkg;

  typedef enum logic {
    MODE_STATIC  = 1'b0,
    MODE_BREATHE = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: shadow duty/mode registers, active duty swapped in only at period wrap,
// and the saturating breathe ramp. active_duty is a register; no backpressure.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic             wr_mode,
  input  logic             period_end,
  output logic [WIDTH-1:0] active_duty
);

  localparam logic [WIDTH-1:0] DUTY_MAX = '1;
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] shadow_duty_q, shadow_duty_d;
  logic [WIDTH-1:0] active_duty_q, active_duty_d;
  mode_e            shadow_mode_q, shadow_mode_d;
  mode_e            active_mode_q, active_mode_d;
  dir_e             dir_q, dir_d;

  logic [WIDTH-1:0] load_duty;
  mode_e            load_mode;
  dir_e             step_dir;
  logic [WIDTH:0]   up_sum;
  logic             up_sat;
  logic             dn_sat;

  always_comb begin
    // A write landing in the wrap cycle is what the next period uses.
    load_duty = wr_sel ? wr_duty : shadow_duty_q;
    load_mode = wr_sel ? mode_e'(wr_mode) : shadow_mode_q;
    step_dir  = (active_mode_q == MODE_STATIC) ? DIR_UP : dir_q;
    up_sum    = {1'b0, active_duty_q} + STEP_X;
    up_sat    = (up_sum >= {1'b0, DUTY_MAX});
    dn_sat    = ({1'b0, active_duty_q} <= STEP_X);

    shadow_duty_d = shadow_duty_q;
    shadow_mode_d = shadow_mode_q;
    active_duty_d = active_duty_q;
    active_mode_d = active_mode_q;
    dir_d         = dir_q;

    if (wr_sel) begin
      shadow_duty_d = wr_duty;
      shadow_mode_d = mode_e'(wr_mode);
    end

    if (period_end) begin
      active_mode_d = load_mode;
      if (load_mode == MODE_STATIC) begin
        active_duty_d = load_duty;
        dir_d         = DIR_UP;
      end else if (step_dir == DIR_UP) begin
        active_duty_d = up_sat ? DUTY_MAX : up_sum[WIDTH-1:0];
        dir_d         = up_sat ? DIR_DOWN : DIR_UP;
      end else begin
        active_duty_d = dn_sat ? '0 : (active_duty_q - STEP_X[WIDTH-1:0]);
        dir_d         = dn_sat ? DIR_UP : DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_duty_q <= '0;
      shadow_mode_q <= MODE_STATIC;
      active_duty_q <= '0;
      active_mode_q <= MODE_STATIC;
      dir_q         <= DIR_UP;
    end else begin
      shadow_duty_q <= shadow_duty_d;
      shadow_mode_q <= shadow_mode_d;
      active_duty_q <= active_duty_d;
      active_mode_q <= active_mode_d;
      dir_q         <= dir_d;
    end
  end

  assign active_duty = active_duty_q;

endmodule

// File: rtl/pwm_led_bank.sv
// Bank of PWM LED drivers sharing one prescaler and period counter.
// led is registered one cycle behind cnt; period_end is combinational at wrap; no backpressure.
module pwm_led_bank
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int STEP     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [4:0]          wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  input  logic                wr_mode,
  output logic [CHANNELS-1:0] led,
  output logic                period_end
);

  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  logic [PSC_W-1:0]    psc_q, psc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic                tick;
  logic [CHANNELS-1:0] wr_sel;
  logic [WIDTH-1:0]    active_duty [CHANNELS];

  assign tick       = enable && (psc_q == PSC_LAST);
  assign period_end = tick && (cnt_q == CNT_MAX);
  assign led        = led_q;

  always_comb begin
    // Disabling parks the timebase at zero so re-enable starts a fresh period.
    psc_d = '0;
    cnt_d = '0;
    if (enable) begin
      psc_d = tick ? '0 : (psc_q + PSC_W'(1));
      cnt_d = tick ? (cnt_q + WIDTH'(1)) : cnt_q;
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      led_d[i] = enable && (cnt_q < active_duty[i]);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr_sel[i] = wr_en && (wr_ch == 5'(i));

    pwm_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .wr_sel      (wr_sel[i]),
      .wr_duty     (wr_duty),
      .wr_mode     (wr_mode),
      .period_end  (period_end),
      .active_duty (active_duty[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_q <= '0;
      cnt_q <= '0;
      led_q <= '0;
    end else begin
      psc_q <= psc_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

endmodule

// File: tb/tb_pwm_led_bank.sv
// Bench for pwm_led_bank (2 channels, 4-bit, prescale 1, step 4): per-cycle reference model,
// table of duty writes measured as high counts per period, and hand-built corner sequences.
module tb_pwm_led_bank;

  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int PS   = 1;
  localparam int ST   = 4;
  localparam int MAXD = 15;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          wr_en;
  logic [4:0]    wr_ch;
  logic [W-1:0]  wr_duty;
  logic          wr_mode;
  logic [CH-1:0] led;
  logic          period_end;

  int total;
  int bad;

  // Reference model state, kept as plain integers.
  int            m_cnt;
  int            m_sh_d [CH];
  int            m_sh_m [CH];
  int            m_ac_d [CH];
  int            m_ac_m [CH];
  int            m_dir  [CH];
  logic [CH-1:0] m_led;

  logic          last_pe;
  logic [CH-1:0] last_led;

  typedef struct {
    logic [4:0] ch;
    logic [3:0] duty;
    logic       mode;
    int         exp0;
    int         exp1;
  } vec_t;

  vec_t vecs [8];
  int   bexp [10] = '{0, 4, 8, 12, 15, 11, 7, 3, 0, 4};

  pwm_led_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .PRESCALE (PS),
    .STEP     (ST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .wr_mode    (wr_mode),
    .led        (led),
    .period_end (period_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "bench stalled");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0;
    m_led = '0;
    for (int i = 0; i < CH; i++) begin
      m_sh_d[i] = 0;
      m_sh_m[i] = 0;
      m_ac_d[i] = 0;
      m_ac_m[i] = 0;
      m_dir[i]  = 1;
    end
  endtask

  task automatic model_step();
    logic pe;
    logic hit;
    int   eff_d, eff_m, d, r;
    pe = enable && (m_cnt == MAXD);
    for (int i = 0; i < CH; i++) m_led[i] = enable && (m_cnt < m_ac_d[i]);
    if (pe) begin
      for (int i = 0; i < CH; i++) begin
        hit   = wr_en && (int'(wr_ch) == i);
        eff_d = hit ? int'(wr_duty) : m_sh_d[i];
        eff_m = hit ? int'(wr_mode) : m_sh_m[i];
        if (eff_m == 0) begin
          m_ac_d[i] = eff_d;
          m_dir[i]  = 1;
        end else begin
          d = (m_ac_m[i] == 0) ? 1 : m_dir[i];
          r = m_ac_d[i] + d * ST;
          if (r >= MAXD) begin
            r = MAXD;
            d = -1;
          end else if (r <= 0) begin
            r = 0;
            d = 1;
          end
          m_ac_d[i] = r;
          m_dir[i]  = d;
        end
        m_ac_m[i] = eff_m;
      end
    end
    if (wr_en && int'(wr_ch) < CH) begin
      m_sh_d[int'(wr_ch)] = int'(wr_duty);
      m_sh_m[int'(wr_ch)] = int'(wr_mode);
    end
    m_cnt = enable ? (m_cnt + 1) % (MAXD + 1) : 0;
  endtask

  // One clock: check outputs mid-cycle, advance model on the edge, drop the write strobe.
  task automatic cyc();
    @(negedge clk);
    chk("led", led, m_led);
    chk("period_end", period_end, (enable && m_cnt == MAXD) ? 1 : 0);
    last_pe  = period_end;
    last_led = led;
    @(posedge clk);
    if (!reset) m_reset();
    else model_step();
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_pe();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (last_pe) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_period_end", got, 1);
  endtask

  task automatic measure(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      c0 += int'(last_led[0]);
      c1 += int'(last_led[1]);
    end
  endtask

  task automatic do_write(input logic [4:0] ch, input logic [3:0] duty, input logic mode);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_duty = duty;
    wr_mode = mode;
  endtask

  initial begin
    int c0, c1, n;
    logic got;

    vecs[0] = '{5'd0,  4'd5,  1'b0, 5,  0};
    vecs[1] = '{5'd1,  4'd15, 1'b0, 5,  15};
    vecs[2] = '{5'd3,  4'd9,  1'b0, 5,  15};
    vecs[3] = '{5'd1,  4'd0,  1'b0, 5,  0};
    vecs[4] = '{5'd0,  4'd0,  1'b0, 0,  0};
    vecs[5] = '{5'd0,  4'd15, 1'b0, 15, 0};
    vecs[6] = '{5'd1,  4'd9,  1'b0, 15, 9};
    vecs[7] = '{5'd31, 4'd7,  1'b0, 15, 9};

    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    enable  = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_duty = '0;
    wr_mode = 1'b0;
    m_reset();

    cyc();
    cyc();
    chk("reset_led", led, 0);
    chk("reset_period_end", period_end, 0);

    reset  = 1'b1;
    enable = 1'b1;

    // Static duty writes, each measured over the period after it takes effect.
    for (int v = 0; v < 8; v++) begin
      do_write(vecs[v].ch, vecs[v].duty, vecs[v].mode);
      cyc();
      wait_pe();
      measure(c0, c1);
      chk($sformatf("vec%0d_ch0_high", v), c0, vecs[v].exp0);
      chk($sformatf("vec%0d_ch1_high", v), c1, vecs[v].exp1);
    end

    // Write landing exactly in the wrap cycle is used by the next period.
    for (int k = 0; k < 15; k++) cyc();
    do_write(5'd0, 4'd3, 1'b0);
    cyc();
    chk("coincident_wrap_seen", last_pe, 1);
    measure(c0, c1);
    chk("coincident_ch0_high", c0, 3);
    chk("coincident_ch1_high", c1, 9);

    // Mid-period duty change must not disturb the running period.
    do_write(5'd0, 4'd5, 1'b0);
    cyc();
    wait_pe();
    c0 = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) do_write(5'd0, 4'd12, 1'b0);
      cyc();
      c0 += int'(last_led[0]);
    end
    chk("midchange_old_period", c0, 5);
    measure(c0, c1);
    chk("midchange_new_period", c0, 12);

    // Breathe ramp from zero on channel 1.
    do_write(5'd1, 4'd0, 1'b0);
    cyc();
    wait_pe();
    for (int p = 0; p < 10; p++) begin
      if (p == 0) do_write(5'd1, 4'd0, 1'b1);
      measure(c0, c1);
      chk($sformatf("breathe_p%0d", p), c1, bexp[p]);
    end

    // Enable dropped mid-period; re-enable restarts from cnt 0.
    for (int k = 0; k < 6; k++) cyc();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    chk("disabled_led", led, 0);
    enable = 1'b1;
    n   = 0;
    c0  = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      n++;
      c0 += int'(last_led[0]);
      if (last_pe) begin
        got = 1'b1;
        break;
      end
    end
    chk("reenable_wrap_seen", got, 1);
    chk("reenable_period_len", n, 16);
    chk("reenable_ch0_high", c0, 12);

    // Asynchronous reset at cnt 7 while led[0] is high.
    for (int k = 0; k < 7; k++) cyc();
    chk("pre_reset_led0", led[0], 1);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_led", led, 0);
    chk("async_reset_period_end", period_end, 0);
    m_reset();
    for (int k = 0; k < 3; k++) cyc();
    reset = 1'b1;
    measure(c0, c1);
    chk("post_reset_ch0_high", c0, 0);
    chk("post_reset_ch1_high", c1, 0);
    chk("post_reset_wrap_at_16", last_pe, 1);

    // Random writes and enable toggles against the model.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 3) == 0) begin
        do_write(5'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
